// File: rtl/aes256_key_scheduler.sv
// Sequential AES-256 round-key generator: one keyExpansion step per key pair, valid/ready output stream.
// Optional KS_RK_BUF_EN adds a 15-entry round-key buffer and a replay input for reverse-order streaming.
module aes256_key_scheduler (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key_in,
  input  logic         key_load,
  output logic         key_busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         ks_done
`ifdef KS_RK_BUF_EN
  ,
  input  logic         replay
`endif
);

  // state  | meaning
  // IDLE   | waiting for key_load (or replay when the buffer is enabled)
  // STREAM | presenting round keys, advancing on each handshake
  // DONE   | one-cycle ks_done pulse, a new key_load is accepted here
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One AES-256 expansion step: eight old words in, eight new words out.
  function automatic logic [255:0] key_expansion(input logic [3:0] rc, input logic [255:0] key);
    logic [31:0] w [8];
    logic [31:0] n [8];
    logic [7:0]  rcon;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    rcon = 8'h01 << (rc - 4'd1);
    n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h0};
    n[1] = w[1] ^ n[0];
    n[2] = w[2] ^ n[1];
    n[3] = w[3] ^ n[2];
    n[4] = w[4] ^ sub_word(n[3]);
    n[5] = w[5] ^ n[4];
    n[6] = w[6] ^ n[5];
    n[7] = w[7] ^ n[6];
    return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
  endfunction

  state_t         state;
  logic [255:0]   cur;
  logic [3:0]     rc;
  logic           half;
  logic           hs;
  logic           last;
  logic [127:0]   fwd_key;

  assign hs      = rk_valid && rk_ready;
  assign fwd_key = half ? cur[127:0] : cur[255:128];

`ifdef KS_RK_BUF_EN
  logic [127:0] rk_buf [15];
  logic         rev;
  logic         buf_ok;

  assign last   = rev ? (rk_idx == 4'd0) : (rk_idx == 4'd14);
  assign rk_out = rev ? rk_buf[rk_idx] : fwd_key;

  always_ff @(posedge clk) begin
    if (hs && !rev) rk_buf[rk_idx] <= fwd_key;
  end
`else
  assign last   = (rk_idx == 4'd14);
  assign rk_out = fwd_key;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      rc       <= '0;
      half     <= 1'b0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      key_busy <= 1'b0;
      ks_done  <= 1'b0;
`ifdef KS_RK_BUF_EN
      rev      <= 1'b0;
      buf_ok   <= 1'b0;
`endif
    end else begin
      ks_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (key_load) begin
            state    <= STREAM;
            cur      <= key_in;
            rc       <= 4'd1;
            half     <= 1'b0;
            rk_idx   <= 4'd0;
            rk_valid <= 1'b1;
            key_busy <= 1'b1;
`ifdef KS_RK_BUF_EN
          end else if (state == IDLE && replay && buf_ok) begin
            state    <= STREAM;
            rev      <= 1'b1;
            rk_idx   <= 4'd14;
            rk_valid <= 1'b1;
            key_busy <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        STREAM: begin
          if (hs) begin
            if (last) begin
              state    <= DONE;
              rk_valid <= 1'b0;
              key_busy <= 1'b0;
              ks_done  <= 1'b1;
`ifdef KS_RK_BUF_EN
              rev      <= 1'b0;
              if (!rev) buf_ok <= 1'b1;
            end else if (rev) begin
              rk_idx <= rk_idx - 4'd1;
`endif
            end else begin
              rk_idx <= rk_idx + 4'd1;
              if (!half) begin
                half <= 1'b1;
              end else begin
                // rc saturates at 7: the rc=7 block supplies rk14 and nothing follows it.
                cur  <= key_expansion(rc, cur);
                half <= 1'b0;
                if (rc != 4'd7) rc <= rc + 4'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_key_scheduler.sv
// Directed-vector bench for aes256_key_scheduler using the FIPS-197 C.3 AES-256 key.
// Replay scenarios are compiled in when KS_RK_BUF_EN is defined.
module tb_aes256_key_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key_in;
  logic         key_load;
  logic         key_busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         ks_done;
`ifdef KS_RK_BUF_EN
  logic         replay;
`endif

  int checks = 0;
  int errors = 0;

  logic [255:0] key_a;
  logic [255:0] key_b;
  logic [127:0] exp_rk [15];

  always #5 clk = ~clk;

  aes256_key_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_load (key_load),
    .key_busy (key_busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .ks_done  (ks_done)
`ifdef KS_RK_BUF_EN
    ,
    .replay   (replay)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [255:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    key_in   = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    rk_ready = 1'b1;
    while (!ks_done && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (ks_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain: ks_done=%b required 1 within 40 cycles", tag, ks_done);
    end
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      key_in   = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
      key_load = 1'($urandom_range(0, 1));
      rk_ready = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    if (rk_out !== 128'h0) begin errors++; $display("FAIL reset_rk_out: got %h required 0", rk_out); end
    checks++;
    if (rk_idx !== 4'd0) begin errors++; $display("FAIL reset_rk_idx: got %0d required 0", rk_idx); end
    checks++;
    if ({key_busy, rk_valid, ks_done} !== 3'b000)
      begin errors++; $display("FAIL reset_flags: busy/valid/done=%b required 000", {key_busy, rk_valid, ks_done}); end
    key_load = 1'b0;
    rk_ready = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({key_busy, rk_valid} !== 2'b00)
      begin errors++; $display("FAIL reset_release: busy/valid=%b required 00", {key_busy, rk_valid}); end
  endtask

  task automatic test_stream;
    rk_ready = 1'b1;
    start_load(key_a);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (rk_valid !== 1'b1 || key_busy !== 1'b1 || rk_idx !== 4'(i) || rk_out !== exp_rk[i]) begin
        errors++;
        $display("FAIL stream_rk%0d: valid=%b busy=%b idx=%0d key=%h required valid=1 busy=1 idx=%0d key=%h",
                 i, rk_valid, key_busy, rk_idx, rk_out, i, exp_rk[i]);
      end
      tick();
    end
    checks++;
    if ({ks_done, key_busy, rk_valid} !== 3'b100)
      begin errors++; $display("FAIL stream_done: done/busy/valid=%b required 100", {ks_done, key_busy, rk_valid}); end
    tick();
    checks++;
    if (ks_done !== 1'b0) begin errors++; $display("FAIL stream_done_pulse: ks_done=%b required 0", ks_done); end
  endtask

  task automatic test_backpressure;
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    rk_ready = 1'b0;
    start_load(key_a);
    while (idx < 15 && cyc < 300) begin
      rk_ready = 1'($urandom_range(0, 1));
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(idx) || rk_out !== exp_rk[idx]) begin
        errors++;
        $display("FAIL backpressure_rk%0d: valid=%b idx=%0d key=%h required valid=1 idx=%0d key=%h",
                 idx, rk_valid, rk_idx, rk_out, idx, exp_rk[idx]);
      end
      if (rk_ready) idx++;
      tick();
      cyc++;
    end
    checks++;
    if (idx != 15 || ks_done !== 1'b1)
      begin errors++; $display("FAIL backpressure_end: keys=%0d done=%b required 15 keys and done=1", idx, ks_done); end
    rk_ready = 1'b1;
    tick();
  endtask

  task automatic test_load_ignored;
    rk_ready = 1'b1;
    start_load(key_a);
    for (int i = 0; i < 15; i++) begin
      if (i == 5) begin
        key_in   = key_b;
        key_load = 1'b1;
      end else begin
        key_load = 1'b0;
      end
      checks++;
      if (rk_idx !== 4'(i) || rk_out !== exp_rk[i]) begin
        errors++;
        $display("FAIL busy_load_rk%0d: idx=%0d key=%h required idx=%0d key=%h", i, rk_idx, rk_out, i, exp_rk[i]);
      end
      tick();
    end
    checks++;
    if (ks_done !== 1'b1) begin errors++; $display("FAIL done_load_state: ks_done=%b required 1", ks_done); end
    start_load(key_b);
    checks++;
    if (rk_valid !== 1'b1 || key_busy !== 1'b1 || rk_idx !== 4'd0 || rk_out !== key_b[255:128]) begin
      errors++;
      $display("FAIL done_load_rk0: valid=%b busy=%b idx=%0d key=%h required 1 1 0 %h",
               rk_valid, key_busy, rk_idx, rk_out, key_b[255:128]);
    end
    tick();
    checks++;
    if (rk_idx !== 4'd1 || rk_out !== key_b[127:0])
      begin errors++; $display("FAIL done_load_rk1: idx=%0d key=%h required 1 %h", rk_idx, rk_out, key_b[127:0]); end
    drain("done_load");
  endtask

  task automatic test_reset_mid;
    rk_ready = 1'b1;
    start_load(key_a);
    repeat (9) tick();
    checks++;
    if (rk_idx !== 4'd9 || rk_out !== exp_rk[9])
      begin errors++; $display("FAIL midreset_pre: idx=%0d key=%h required 9 %h", rk_idx, rk_out, exp_rk[9]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_busy, rk_valid, ks_done} !== 3'b000 || rk_out !== 128'h0 || rk_idx !== 4'd0) begin
      errors++;
      $display("FAIL midreset_outputs: busy/valid/done=%b idx=%0d key=%h required 000 0 0",
               {key_busy, rk_valid, ks_done}, rk_idx, rk_out);
    end
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (rk_valid !== 1'b0) begin errors++; $display("FAIL midreset_idle: rk_valid=%b required 0", rk_valid); end
    start_load(key_a);
    checks++;
    if (rk_idx !== 4'd0 || rk_out !== exp_rk[0])
      begin errors++; $display("FAIL midreset_reload_rk0: idx=%0d key=%h required 0 %h", rk_idx, rk_out, exp_rk[0]); end
    tick();
    checks++;
    if (rk_idx !== 4'd1 || rk_out !== exp_rk[1])
      begin errors++; $display("FAIL midreset_reload_rk1: idx=%0d key=%h required 1 %h", rk_idx, rk_out, exp_rk[1]); end
    drain("midreset");
  endtask

`ifdef KS_RK_BUF_EN
  task automatic test_replay_ignored;
    replay = 1'b1;
    tick();
    replay = 1'b0;
    checks++;
    if ({key_busy, rk_valid} !== 2'b00)
      begin errors++; $display("FAIL replay_after_reset: busy/valid=%b required 00", {key_busy, rk_valid}); end
    tick();
  endtask

  task automatic test_replay;
    rk_ready = 1'b1;
    replay   = 1'b1;
    tick();
    replay   = 1'b0;
    for (int i = 14; i >= 0; i--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_out !== exp_rk[i]) begin
        errors++;
        $display("FAIL replay_rk%0d: valid=%b idx=%0d key=%h required valid=1 idx=%0d key=%h",
                 i, rk_valid, rk_idx, rk_out, i, exp_rk[i]);
      end
      tick();
    end
    checks++;
    if ({ks_done, rk_valid} !== 2'b10)
      begin errors++; $display("FAIL replay_done: done/valid=%b required 10", {ks_done, rk_valid}); end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    key_a = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    key_b = 256'hffeeddccbbaa99887766554433221100_0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    exp_rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    exp_rk[1]  = 128'h101112131415161718191a1b1c1d1e1f;
    exp_rk[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
    exp_rk[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
    exp_rk[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
    exp_rk[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
    exp_rk[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
    exp_rk[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
    exp_rk[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
    exp_rk[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
    exp_rk[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
    exp_rk[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
    exp_rk[12] = 128'h2541fe719bf500258813bbd55a721c0a;
    exp_rk[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
    exp_rk[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    key_in   = '0;
    key_load = 1'b0;
    rk_ready = 1'b1;
`ifdef KS_RK_BUF_EN
    replay   = 1'b0;
`endif

    test_reset();
`ifdef KS_RK_BUF_EN
    test_replay_ignored();
`endif
    test_stream();
`ifdef KS_RK_BUF_EN
    test_replay();
`endif
    test_backpressure();
    test_load_ignored();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
